// File: rtl/word_packer_if.sv
// word_packer_if: byte-in handshake plus word-out FIFO write port for word_packer.
interface word_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_last;
  logic                    in_ready;
  logic                    full;
  logic                    wr;
  logic [2*DATA_WIDTH-1:0] w_data;
  logic [CNT_WIDTH-1:0]    word_count;
  modport master (output in_valid, in_data, in_last, full, input in_ready, wr, w_data, word_count);
  modport slave  (input in_valid, in_data, in_last, full, output in_ready, wr, w_data, word_count);
endinterface

// File: rtl/word_packer.sv
// word_packer: packs bytes into 2-byte words (first byte low) for a 2:1 width FIFO,
// flushing a partial word on in_last and counting written words with saturation.
module word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic         clk,
  input logic         reset,
  word_packer_if.slave bus
);
  typedef enum logic {LOW_EMPTY, LOW_HELD} state_t;
  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   low;
  logic [2*DATA_WIDTH-1:0] word;
  logic                    word_valid;
  logic [CNT_WIDTH-1:0]    count;
  logic                    accept, complete;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= LOW_EMPTY;
    else        state <= state_nxt;
  always_comb
    state_nxt = accept ? ((state == LOW_EMPTY && !bus.in_last) ? LOW_HELD : LOW_EMPTY) : state;
  // A pending word blocked by full stalls upstream; otherwise a byte can enter every cycle.
  always_comb begin
    bus.in_ready   = !word_valid || !bus.full;
    bus.wr         = word_valid && !bus.full;
    bus.w_data     = word;
    bus.word_count = count;
    accept         = bus.in_valid && (!word_valid || !bus.full);
    complete       = accept && (state == LOW_HELD || bus.in_last);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      low        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      count      <= '0;
    end else begin
      if (accept && state == LOW_EMPTY && !bus.in_last) low <= bus.in_data;
      if (complete) begin
        word       <= state == LOW_HELD ? {bus.in_data, low} : {{DATA_WIDTH{1'b0}}, bus.in_data};
        word_valid <= 1'b1;
      end else if (bus.wr) word_valid <= 1'b0;
      if (bus.wr && count != '1) count <= count + 1'b1;
    end
endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed vector table, reset sequences and random traffic checked
// against a queue-based model of the byte stream and the pending FIFO word.
module tb_word_packer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  word_packer_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
  word_packer_if #(.DATA_WIDTH(8), .CNT_WIDTH(2))  bus2 ();
  assign bus2.in_valid = bus.in_valid;
  assign bus2.in_data  = bus.in_data;
  assign bus2.in_last  = bus.in_last;
  assign bus2.full     = bus.full;

  word_packer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  word_packer #(.DATA_WIDTH(8), .CNT_WIDTH(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int tests = 0;
  int fails = 0;

  logic [7:0]  held[$];
  logic [15:0] pend[$];
  logic [15:0] mwd;
  int          mcnt;

  typedef struct {
    bit v; logic [7:0] d; bit l; bit f;
    bit ewr; bit erdy; logic [15:0] ewd; int ecnt;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    held.delete();
    pend.delete();
    mwd  = 16'h0;
    mcnt = 0;
  endtask

  function automatic bit m_ready();
    return pend.size() == 0 || !bus.full;
  endfunction

  function automatic bit m_wr();
    return pend.size() != 0 && !bus.full;
  endfunction

  task automatic drive(bit v, logic [7:0] d, bit l, bit f);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.full     = f;
    #1;
    chk("wr", {31'b0, bus.wr}, {31'b0, m_wr()});
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, m_ready()});
    chk("w_data", {16'b0, bus.w_data}, {16'b0, mwd});
    chk("word_count", {16'b0, bus.word_count}, mcnt);
    chk("word_count_sat2", {30'b0, bus2.word_count}, mcnt > 3 ? 3 : mcnt);
    chk("wr_cnt2", {31'b0, bus2.wr}, {31'b0, m_wr()});
  endtask

  task automatic tick();
    bit rdy, w;
    logic [15:0] x;
    @(posedge clk);
    rdy = m_ready();
    w   = m_wr();
    if (w) begin
      void'(pend.pop_front());
      mcnt++;
    end
    if (bus.in_valid && rdy) begin
      held.push_back(bus.in_data);
      if (held.size() == 2 || bus.in_last) begin
        x = held.size() == 2 ? {held[1], held[0]} : {8'h00, held[0]};
        pend.push_back(x);
        mwd = x;
        held.delete();
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1, 8'h11, 0, 0, 0, 1, 16'h0000, 0};
    tbl[1]  = '{1, 8'h22, 0, 0, 0, 1, 16'h0000, 0};
    tbl[2]  = '{1, 8'h33, 0, 0, 1, 1, 16'h2211, 0};
    tbl[3]  = '{1, 8'h44, 0, 0, 0, 1, 16'h2211, 1};
    tbl[4]  = '{0, 8'h00, 0, 0, 1, 1, 16'h4433, 1};
    tbl[5]  = '{0, 8'h00, 0, 0, 0, 1, 16'h4433, 2};
    tbl[6]  = '{1, 8'hAB, 1, 0, 0, 1, 16'h4433, 2};
    tbl[7]  = '{0, 8'h00, 0, 0, 1, 1, 16'h00AB, 2};
    tbl[8]  = '{0, 8'h00, 0, 0, 0, 1, 16'h00AB, 3};
    tbl[9]  = '{1, 8'h01, 0, 0, 0, 1, 16'h00AB, 3};
    tbl[10] = '{1, 8'h02, 1, 0, 0, 1, 16'h00AB, 3};
    tbl[11] = '{0, 8'h00, 0, 0, 1, 1, 16'h0201, 3};
    tbl[12] = '{0, 8'h00, 0, 0, 0, 1, 16'h0201, 4};
    tbl[13] = '{1, 8'h11, 0, 0, 0, 1, 16'h0201, 4};
    tbl[14] = '{1, 8'h22, 0, 0, 0, 1, 16'h0201, 4};
    for (int i = 15; i < 20; i++) tbl[i] = '{1, 8'h33, 0, 1, 0, 0, 16'h2211, 4};
    tbl[20] = '{1, 8'h33, 0, 0, 1, 1, 16'h2211, 4};
    tbl[21] = '{0, 8'h00, 0, 0, 0, 1, 16'h2211, 5};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.full     = 1'b0;
    model_reset();
    #1;
    chk("reset_wr", {31'b0, bus.wr}, 0);
    chk("reset_ready", {31'b0, bus.in_ready}, 1);
    chk("reset_wdata", {16'b0, bus.w_data}, 0);
    chk("reset_count", {16'b0, bus.word_count}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f);
      chk($sformatf("vec%0d_wr", i), {31'b0, bus.wr}, {31'b0, tbl[i].ewr});
      chk($sformatf("vec%0d_ready", i), {31'b0, bus.in_ready}, {31'b0, tbl[i].erdy});
      chk($sformatf("vec%0d_wdata", i), {16'b0, bus.w_data}, {16'b0, tbl[i].ewd});
      chk($sformatf("vec%0d_count", i), {16'b0, bus.word_count}, tbl[i].ecnt);
      tick();
    end
    chk("cnt2_saturated", {30'b0, bus2.word_count}, 3);

    // Pending word visible on wr, then reset asserted mid-cycle.
    drive(1, 8'h44, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("pre_rst_wr", {31'b0, bus.wr}, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_wr", {31'b0, bus.wr}, 0);
    chk("rst_count", {16'b0, bus.word_count}, 0);
    chk("rst_ready", {31'b0, bus.in_ready}, 1);
    chk("rst_wdata", {16'b0, bus.w_data}, 0);
    chk("rst_count2", {30'b0, bus2.word_count}, 0);
    @(negedge clk);
    reset = 1'b1;

    // Held low byte discarded by reset.
    drive(1, 8'h77, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst2_ready", {31'b0, bus.in_ready}, 1);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 8'h55, 0, 0);
    tick();
    drive(1, 8'h66, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("post_rst_wdata", {16'b0, bus.w_data}, 16'h6655);
    chk("post_rst_wr", {31'b0, bus.wr}, 1);
    tick();

    // Held byte retained across a long idle gap.
    drive(1, 8'h9C, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 8'h00, 0, 0);
      tick();
    end
    drive(1, 8'hC9, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("idle_hold_wdata", {16'b0, bus.w_data}, 16'hC99C);
    tick();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the width of one input byte and of one FIFO read half-word.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, meaning the width of the written-word counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The module SHALL have port in_valid, input, 1 bit: an upstream byte is offered.
REQ-006 The module SHALL have port in_data, input, DATA_WIDTH bits: the offered byte.
REQ-007 The module SHALL have port in_last, input, 1 bit: the offered byte ends a packet and forces flush of any partial word.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the packer accepts in_data this cycle.
REQ-009 The module SHALL have port full, input, 1 bit: full status from the downstream 2:1 width FIFO.
REQ-010 The module SHALL have port wr, output, 1 bit: write strobe to the downstream FIFO.
REQ-011 The module SHALL have port w_data, output, 2*DATA_WIDTH bits: packed word to the downstream FIFO.
REQ-012 The module SHALL have port word_count, output, CNT_WIDTH bits: number of words written since reset.

Function
REQ-013 A byte SHALL be accepted exactly in cycles where in_valid and in_ready are both 1.
REQ-014 The packer SHALL have two fill states: LOW_EMPTY (no byte held) and LOW_HELD (one byte held in the low half).
REQ-015 An accepted byte in LOW_EMPTY with in_last=0 SHALL be stored as the low half, and the state SHALL become LOW_HELD.
REQ-016 An accepted byte in LOW_HELD SHALL become the high half; the packed word {high, low} SHALL be loaded into the output word register with word_valid=1, and the state SHALL return to LOW_EMPTY.
REQ-017 An accepted byte in LOW_EMPTY with in_last=1 SHALL load the word {DATA_WIDTH zeros, byte} with word_valid=1, and the state SHALL stay LOW_EMPTY.
REQ-018 The first byte received SHALL occupy w_data[DATA_WIDTH-1:0] and the second byte SHALL occupy w_data[2*DATA_WIDTH-1:DATA_WIDTH], so the FIFO emits the low half first.
REQ-019 wr SHALL equal word_valid AND NOT full, combinationally; w_data SHALL be the output word register.
REQ-020 When wr=1, word_valid SHALL clear at the next edge unless a new word is completed in the same cycle, in which case the register SHALL reload and word_valid SHALL stay 1.
REQ-021 in_ready SHALL equal NOT word_valid OR NOT full, so that a pending word blocked by full back-pressures upstream.
REQ-022 While full=1 and word_valid=1, w_data SHALL hold its value and no byte SHALL be accepted.
REQ-023 A held low byte SHALL be retained indefinitely while in_valid=0; no timeout or flush SHALL occur without in_last.
REQ-024 Sustained throughput SHALL be one byte per cycle when full=0, giving one wr every 2 cycles.
REQ-025 word_count SHALL increment by 1 on every cycle with wr=1 and SHALL saturate at all-ones.
REQ-026 The latency from acceptance of the completing byte to wr SHALL be 1 cycle when full=0.

Reset
REQ-027 On reset=0, asynchronously: the state SHALL be LOW_EMPTY, word_valid=0, w_data=0, word_count=0, and wr=0.
REQ-028 On reset=0, in_ready SHALL equal 1, and any held byte or pending word SHALL be discarded.
REQ-029 Reset deassertion SHALL take effect at the next rising clk edge, and the first byte SHALL be accepted on that edge or later.

Verification
REQ-030 Bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles with full=0 -> wr pulses carry w_data 0x2211 then 0x4433, and word_count=2.
REQ-031 Byte 0xAB with in_last=1 from LOW_EMPTY -> the next cycle gives wr=1 with w_data=0x00AB.
REQ-032 Byte 0x01, then 0x02 with in_last=1 -> a single word 0x0201 with no padding word.
REQ-033 Word 0x2211 pending with full held at 1 for 5 cycles -> wr=0, in_ready=0, and w_data stable; full drops to 0 -> wr=1 in the same cycle and in_ready=1.
REQ-034 reset pulled low while LOW_HELD with word_valid=1 -> wr=0 and word_count=0 immediately; after release, bytes 0x55, 0x66 -> w_data=0x6655.
REQ-035 With CNT_WIDTH=2, 5 words written -> word_count reaches 3 and holds at 3.
